// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch PC register with redirect priority and AdEL tagging
//
// Purpose: holds the fetch PC. The first edge after reset is a boot edge that keeps
// PC_RESET. After that the PC follows exception entry, eret return, stall hold,
// taken branch/jump, or sequential +4, in that priority order.
// Optional feature: define IF_FETCH_CNT_EN to add the fetchCnt fetch counter output.
//
// Ports:
//    clk         in   1   sole clock, rising edge
//    reset       in   1   asynchronous active-low reset
//    ifStall     in   1   hold fetch (IF/ID also holding)
//    flush_Mem   in   1   exception/interrupt accepted in Mem -> EXC_ENTRY
//    eret_Mem    in   1   eret committing in Mem -> epc_Mem
//    epc_Mem     in  32   eret return address
//    npcSel_Id   in   1   branch/jump in Id taken
//    npc_Id      in  32   branch/jump target
//    isBj_Id     in   1   instruction in Id is a branch/jump
//    pc_If       out 32   current fetch PC (registered)
//    excCode_If  out  5   fetch exception code, 4 = AdEL (registered)
//    ifBd_If     out  1   current fetch sits in a delay slot
//    reset_If    out  1   first-fetch marker (high in BOOT)
//    fetchCnt    out 32   fetch counter (only with IF_FETCH_CNT_EN)
module if_fetch #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ifStall,
   input  logic        flush_Mem,
   input  logic        eret_Mem,
   input  logic [31:0] epc_Mem,
   input  logic        npcSel_Id,
   input  logic [31:0] npc_Id,
   input  logic        isBj_Id,
   output logic [31:0] pc_If,
   output logic [4:0]  excCode_If,
   output logic        ifBd_If,
`ifdef IF_FETCH_CNT_EN
   output logic [31:0] fetchCnt,
`endif
   output logic        reset_If
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  exc_q, exc_d;

   function automatic logic adel(input logic [31:0] pc);
      adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
   endfunction

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      exc_d   = exc_q;
      if (state_q == BOOT) begin
         // Boot edge: the PC stays at PC_RESET so the first fetch is issued twice
         // (once marked with reset_If) and IF/ID can discard the marked copy.
         state_d = RUN;
         pc_d    = PC_RESET;
         exc_d   = adel(PC_RESET) ? EXC_ADEL : EXC_NONE;
      end else begin
         if (flush_Mem)      pc_d = EXC_ENTRY;
         else if (eret_Mem)  pc_d = epc_Mem;
         else if (ifStall)   pc_d = pc_q;
         else if (npcSel_Id) pc_d = npc_Id;
         else                pc_d = pc_q + 32'd4;
         // When holding, pc_d == pc_q so the code recomputes to the held value.
         exc_d = adel(pc_d) ? EXC_ADEL : EXC_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         pc_q    <= PC_RESET;
         exc_q   <= EXC_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         exc_q   <= exc_d;
      end
   end

   assign pc_If      = pc_q;
   assign excCode_If = exc_q;
   assign reset_If   = (state_q == BOOT);
   assign ifBd_If    = isBj_Id & ~reset_If;

`ifdef IF_FETCH_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts edges that actually fetch a new sequential/branch PC in RUN.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == RUN && !ifStall && !flush_Mem && !eret_Mem)
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= 32'd0;
      else        cnt_q <= cnt_d;
   end

   assign fetchCnt = cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        ifStall, flush_Mem, eret_Mem, npcSel_Id, isBj_Id;
   logic [31:0] epc_Mem, npc_Id;
   logic [31:0] pc_If;
   logic [4:0]  excCode_If;
   logic        ifBd_If, reset_If;
`ifdef IF_FETCH_CNT_EN
   logic [31:0] fetchCnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  exc;
      string       tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   if_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .ifStall    (ifStall),
      .flush_Mem  (flush_Mem),
      .eret_Mem   (eret_Mem),
      .epc_Mem    (epc_Mem),
      .npcSel_Id  (npcSel_Id),
      .npc_Id     (npc_Id),
      .isBj_Id    (isBj_Id),
      .pc_If      (pc_If),
      .excCode_If (excCode_If),
      .ifBd_If    (ifBd_If),
`ifdef IF_FETCH_CNT_EN
      .fetchCnt   (fetchCnt),
`endif
      .reset_If   (reset_If)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      ifStall = 0; flush_Mem = 0; eret_Mem = 0; npcSel_Id = 0; isBj_Id = 0;
      epc_Mem = 32'h0; npc_Id = 32'h0;
   endtask

   // Push the expected post-edge state, advance one edge, then pop and compare.
   task automatic step(input logic [31:0] pc, input logic [4:0] exc, input string tag);
      exp_t e, got;
      e.pc = pc; e.exc = exc; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".pc"}, pc_If, got.pc);
      chk({got.tag, ".exc"}, {27'd0, excCode_If}, {27'd0, got.exc});
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      isBj_Id = 1;
      #13;
      chk("rst.pc", pc_If, 32'h3000);
      chk("rst.exc", {27'd0, excCode_If}, 32'd0);
      chk("rst.reset_If", {31'd0, reset_If}, 32'd1);
      chk("rst.ifBd_masked", {31'd0, ifBd_If}, 32'd0);
      isBj_Id = 0;

      // Release away from the edge; first edge is the boot edge.
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("boot.reset_If", {31'd0, reset_If}, 32'd1);
      step(32'h3000, 5'd0, "boot_edge");
      chk("run.reset_If", {31'd0, reset_If}, 32'd0);
      step(32'h3004, 5'd0, "seq1");
      step(32'h3008, 5'd0, "seq2");
      step(32'h300C, 5'd0, "seq3");
      step(32'h3010, 5'd0, "seq4");

      // Stall masks a taken branch, then the branch lands.
      ifStall = 1; npcSel_Id = 1; npc_Id = 32'h3100;
      step(32'h3010, 5'd0, "stall1");
      step(32'h3010, 5'd0, "stall2");
      ifStall = 0;
      step(32'h3100, 5'd0, "branch");
      npcSel_Id = 0;

      // Flush beats eret and stall.
      flush_Mem = 1; eret_Mem = 1; ifStall = 1; epc_Mem = 32'h3200;
      step(32'h4180, 5'd0, "flush_prio");
      clear_inputs();

      // Misaligned eret target, then keeps advancing with AdEL.
      eret_Mem = 1; epc_Mem = 32'h3002; ifStall = 1;
      step(32'h3002, 5'd4, "eret_mis");
      clear_inputs();
      step(32'h3006, 5'd4, "eret_mis_seq");
      ifStall = 1;
      step(32'h3006, 5'd4, "adel_hold");
      ifStall = 0;

      // Upper boundary of instruction memory.
      npcSel_Id = 1; npc_Id = 32'h6FFC; isBj_Id = 1;
      #1;
      chk("ifBd", {31'd0, ifBd_If}, 32'd1);
      step(32'h6FFC, 5'd0, "limit");
      clear_inputs();
      #1;
      chk("ifBd_off", {31'd0, ifBd_If}, 32'd0);
      step(32'h7000, 5'd4, "over_limit");

      // Lower boundary and wrap.
      npcSel_Id = 1; npc_Id = 32'h2FFC;
      step(32'h2FFC, 5'd4, "under_base");
      npc_Id = 32'hFFFF_FFFC;
      step(32'hFFFF_FFFC, 5'd4, "top");
      npcSel_Id = 0;
      step(32'h0000_0000, 5'd4, "wrap");
      npcSel_Id = 1; npc_Id = 32'h3000;
      step(32'h3000, 5'd0, "base");
      clear_inputs();

      // Reset asserted mid-redirect discards the pending flush.
      flush_Mem = 1;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid.pc", pc_If, 32'h3000);
      chk("rst_mid.reset_If", {31'd0, reset_If}, 32'd1);
      @(posedge clk);
      #1;
      chk("rst_hold.pc", pc_If, 32'h3000);
      clear_inputs();
      @(negedge clk);
      reset = 1'b1;
      step(32'h3000, 5'd0, "reboot");
      step(32'h3004, 5'd0, "reboot_seq");

`ifdef IF_FETCH_CNT_EN
      // Counter: fresh reset, boot edge does not count.
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("cnt.rst", fetchCnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(32'h3000, 5'd0, "cnt_boot");
      for (int i = 0; i < 5; i++) step(32'h3004 + 32'(4 * i), 5'd0, "cnt_free");
      ifStall = 1;
      step(32'h3014, 5'd0, "cnt_st1");
      step(32'h3014, 5'd0, "cnt_st2");
      ifStall = 0; flush_Mem = 1;
      step(32'h4180, 5'd0, "cnt_flush");
      clear_inputs();
      chk("cnt.value", fetchCnt, 32'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("cnt.async_clr", fetchCnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
`endif

      chk("sb.empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
